// File: rtl/fp_div_special_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_pkg : shared types and helpers for the divider special-case path  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fp_pkg;

  typedef enum logic [2:0] {
    ZERO      = 3'd0,
    SUBNORMAL = 3'd1,
    NORMAL    = 3'd2,
    INF       = 3'd3,
    QNAN      = 3'd4,
    SNAN      = 3'd5
  } fp_class_e;

  localparam int MAX_W = 128;

  // Canonical qNaN: sign 0, exponent all ones, fraction MSB set, rest clear.
  function automatic logic [MAX_W-1:0] canonical_qnan(input int exp_w, input int frac_w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i >= frac_w - 1) && (i < frac_w + exp_w)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_div_special_classify.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_classify : combinational IEEE-754 operand classifier              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W-1:0]  exp_f,
  input  logic [FRAC_W-1:0] frac_f,
  output fp_class_e         cls
);

  always_comb begin
    cls = NORMAL;
    if (&exp_f) begin
      if (frac_f == '0)          cls = INF;
      else if (frac_f[FRAC_W-1]) cls = QNAN;
      else                       cls = SNAN;
    end else if (exp_f == '0) begin
      cls = (frac_f == '0) ? ZERO : SUBNORMAL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_div_special.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_div_special : two-stage special-operand resolver for the divider  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_div_special
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output fp_class_e             a_class,
  output fp_class_e             b_class,
  output logic                  special,
  output logic [EXP_W+FRAC_W:0] sp_result,
  output logic                  q_sign,
  input  logic                  clr_status,
  output logic                  st_invalid,
  output logic                  st_divzero
);

  localparam int              W          = 1 + EXP_W + FRAC_W;
  localparam logic [MAX_W-1:0] QNAN_FULL = canonical_qnan(EXP_W, FRAC_W);
  localparam logic [W-1:0]    CANON_QNAN = QNAN_FULL[W-1:0];
  localparam logic [W-1:0]    QUIET_BIT  = {{(EXP_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  fp_class_e a_cls_w, b_cls_w;

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  fp_class_e    s1_a_class_q, s1_a_class_d, s1_b_class_q, s1_b_class_d;
  logic         s1_sign_q, s1_sign_d;

  logic         s2_valid_q, s2_valid_d;
  fp_class_e    s2_a_class_q, s2_a_class_d, s2_b_class_q, s2_b_class_d;
  logic         s2_special_q, s2_special_d;
  logic [W-1:0] s2_result_q, s2_result_d;
  logic         s2_sign_q, s2_sign_d;
  logic         s2_invalid_q, s2_invalid_d, s2_divzero_q, s2_divzero_d;

  logic         st_invalid_q, st_invalid_d, st_divzero_q, st_divzero_d;

  logic         s2_load, s1_load, out_fire;
  logic         res_special, res_invalid, res_divzero;
  logic [W-1:0] res_value;
  logic         a_nan, b_nan, a_zero, b_zero, a_inf, b_inf;

  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (
    .exp_f (a[FRAC_W +: EXP_W]),
    .frac_f(a[FRAC_W-1:0]),
    .cls   (a_cls_w)
  );

  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (
    .exp_f (b[FRAC_W +: EXP_W]),
    .frac_f(b[FRAC_W-1:0]),
    .cls   (b_cls_w)
  );

  // Each stage loads when empty or when its occupant leaves this cycle.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = !rst && s1_load;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_a_class_d = s1_a_class_q;
    s1_b_class_d = s1_b_class_q;
    s1_sign_d    = s1_sign_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d       = a;
        s1_b_d       = b;
        s1_a_class_d = a_cls_w;
        s1_b_class_d = b_cls_w;
        s1_sign_d    = a[W-1] ^ b[W-1];
      end
    end
  end

  always_comb begin
    a_nan       = (s1_a_class_q == QNAN) || (s1_a_class_q == SNAN);
    b_nan       = (s1_b_class_q == QNAN) || (s1_b_class_q == SNAN);
    a_zero      = (s1_a_class_q == ZERO);
    b_zero      = (s1_b_class_q == ZERO);
    a_inf       = (s1_a_class_q == INF);
    b_inf       = (s1_b_class_q == INF);
    res_special = 1'b1;
    res_value   = '0;
    res_invalid = (s1_a_class_q == SNAN) || (s1_b_class_q == SNAN);
    res_divzero = 1'b0;
    if (a_nan) begin
      res_value = s1_a_q | QUIET_BIT;
    end else if (b_nan) begin
      res_value = s1_b_q | QUIET_BIT;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      res_value   = CANON_QNAN;
      res_invalid = 1'b1;
    end else if (a_inf) begin
      res_value = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (b_zero) begin
      res_value   = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      res_divzero = 1'b1;
    end else if (a_zero || b_inf) begin
      res_value = {s1_sign_q, {(W-1){1'b0}}};
    end else begin
      res_special = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_a_class_d = s2_a_class_q;
    s2_b_class_d = s2_b_class_q;
    s2_special_d = s2_special_q;
    s2_result_d  = s2_result_q;
    s2_sign_d    = s2_sign_q;
    s2_invalid_d = s2_invalid_q;
    s2_divzero_d = s2_divzero_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_a_class_d = s1_a_class_q;
        s2_b_class_d = s1_b_class_q;
        s2_special_d = res_special;
        s2_result_d  = res_value;
        s2_sign_d    = s1_sign_q;
        s2_invalid_d = res_invalid;
        s2_divzero_d = res_divzero;
      end
    end
  end

  // Set has priority over clear when both land in the same cycle.
  always_comb begin
    st_invalid_d = (st_invalid_q && !clr_status) || (out_fire && s2_invalid_q);
    st_divzero_d = (st_divzero_q && !clr_status) || (out_fire && s2_divzero_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_a_class_q <= ZERO;
      s1_b_class_q <= ZERO;
      s1_sign_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_a_class_q <= ZERO;
      s2_b_class_q <= ZERO;
      s2_special_q <= 1'b0;
      s2_result_q  <= '0;
      s2_sign_q    <= 1'b0;
      s2_invalid_q <= 1'b0;
      s2_divzero_q <= 1'b0;
      st_invalid_q <= 1'b0;
      st_divzero_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_a_class_q <= s1_a_class_d;
      s1_b_class_q <= s1_b_class_d;
      s1_sign_q    <= s1_sign_d;
      s2_valid_q   <= s2_valid_d;
      s2_a_class_q <= s2_a_class_d;
      s2_b_class_q <= s2_b_class_d;
      s2_special_q <= s2_special_d;
      s2_result_q  <= s2_result_d;
      s2_sign_q    <= s2_sign_d;
      s2_invalid_q <= s2_invalid_d;
      s2_divzero_q <= s2_divzero_d;
      st_invalid_q <= st_invalid_d;
      st_divzero_q <= st_divzero_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign a_class    = s2_a_class_q;
  assign b_class    = s2_b_class_q;
  assign special    = s2_special_q;
  assign sp_result  = s2_result_q;
  assign q_sign     = s2_sign_q;
  assign st_invalid = st_invalid_q;
  assign st_divzero = st_divzero_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_special.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_div_special : directed self-checking bench, 32- and 64-bit DUTs |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fp_div_special;
  import fp_pkg::*;

  typedef struct {
    logic [63:0] a, b, res;
    logic        spec;
    fp_class_e   ac, bc;
    logic        qs, inv, dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_status = 1'b0;
  logic sel64 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic        iv32 = 1'b0, or32 = 1'b1, ir32, ov32, sp32, qs32, inv32, dz32;
  logic [31:0] a32 = '0, b32 = '0, res32;
  fp_class_e   ac32, bc32;
  logic        iv64 = 1'b0, or64 = 1'b1, ir64, ov64, sp64, qs64, inv64, dz64;
  logic [63:0] a64 = '0, b64 = '0, res64;
  fp_class_e   ac64, bc64;

  fp_div_special #(.EXP_W(8), .FRAC_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .a_class(ac32), .b_class(bc32),
    .special(sp32), .sp_result(res32), .q_sign(qs32), .clr_status(clr_status),
    .st_invalid(inv32), .st_divzero(dz32)
  );

  fp_div_special #(.EXP_W(11), .FRAC_W(52)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(or64), .a_class(ac64), .b_class(bc64),
    .special(sp64), .sp_result(res64), .q_sign(qs64), .clr_status(clr_status),
    .st_invalid(inv64), .st_divzero(dz64)
  );

  logic [63:0] m_res;
  logic        m_ov, m_sp, m_qs, m_inv, m_dz;
  fp_class_e   m_ac, m_bc;
  assign m_res = sel64 ? res64 : {32'd0, res32};
  assign m_ov  = sel64 ? ov64  : ov32;
  assign m_sp  = sel64 ? sp64  : sp32;
  assign m_qs  = sel64 ? qs64  : qs32;
  assign m_inv = sel64 ? inv64 : inv32;
  assign m_dz  = sel64 ? dz64  : dz32;
  assign m_ac  = sel64 ? ac64  : ac32;
  assign m_bc  = sel64 ? bc64  : bc32;

  task automatic drive(input logic v, input logic [63:0] av, input logic [63:0] bv);
    if (sel64) begin
      iv64 = v; a64 = av; b64 = bv;
    end else begin
      iv32 = v; a32 = av[31:0]; b32 = bv[31:0];
    end
  endtask

  // Clears the sticky flags, sends one pair with out_ready high and captures the result.
  task automatic apply_pair(input logic [63:0] av, input logic [63:0] bv, output int lat,
                            output logic [63:0] res, output logic spec, output fp_class_e ac,
                            output fp_class_e bc, output logic qs, output logic inv, output logic dz);
    @(negedge clk);
    clr_status = 1'b1; or32 = 1'b1; or64 = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    drive(1'b1, av, bv);
    @(negedge clk);
    drive(1'b0, '0, '0);
    lat = 1;
    while (!m_ov && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = m_res; spec = m_sp; ac = m_ac; bc = m_bc; qs = m_qs;
    @(negedge clk);
    inv = m_inv; dz = m_dz;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (ir32 !== 1'b0 || ir64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b expected 0/0", ir32, ir64);
    end
    n_checks++;
    if ({ov32, ov64, sp32, sp64, inv32, dz32, inv64, dz64} !== 8'd0 || res32 !== 32'd0 || res64 !== 64'd0) begin
      n_fail++; $display("FAIL reset_outputs: ov=%b%b sp=%b%b flags=%b%b%b%b expected all 0",
                         ov32, ov64, sp32, sp64, inv32, dz32, inv64, dz64);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ir32 !== 1'b1 || ir64 !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready: got %b/%b expected 1/1", ir32, ir64);
    end
  endtask

  task automatic test_special_table(input logic wide);
    vec_t        v[$];
    int          lat;
    logic [63:0] res;
    logic        spec, qs, inv, dz;
    fp_class_e   ac, bc;
    sel64 = wide;
    if (!wide) begin
      v.push_back('{64'h3F800000, 64'h0,        64'h7F800000, 1'b1, NORMAL, ZERO,      1'b0, 1'b0, 1'b1});
      v.push_back('{64'hBF800000, 64'h0,        64'hFF800000, 1'b1, NORMAL, ZERO,      1'b1, 1'b0, 1'b1});
      v.push_back('{64'h0,        64'h80000000, 64'h7FC00000, 1'b1, ZERO,   ZERO,      1'b1, 1'b1, 1'b0});
      v.push_back('{64'h7F800000, 64'h7F800000, 64'h7FC00000, 1'b1, INF,    INF,       1'b0, 1'b1, 1'b0});
      v.push_back('{64'h7F800001, 64'h3F800000, 64'h7FC00001, 1'b1, SNAN,   NORMAL,    1'b0, 1'b1, 1'b0});
      v.push_back('{64'h3F800000, 64'h7FC00005, 64'h7FC00005, 1'b1, NORMAL, QNAN,      1'b0, 1'b0, 1'b0});
      v.push_back('{64'h40000000, 64'h00000001, 64'h0,        1'b0, NORMAL, SUBNORMAL, 1'b0, 1'b0, 1'b0});
      v.push_back('{64'h80000000, 64'h3F800000, 64'h80000000, 1'b1, ZERO,   NORMAL,    1'b1, 1'b0, 1'b0});
      v.push_back('{64'h7F800000, 64'hBF800000, 64'hFF800000, 1'b1, INF,    NORMAL,    1'b1, 1'b0, 1'b0});
      v.push_back('{64'h3F800000, 64'h7F800000, 64'h0,        1'b1, NORMAL, INF,       1'b0, 1'b0, 1'b0});
      v.push_back('{64'h7FC00001, 64'h7F800002, 64'h7FC00001, 1'b1, QNAN,   SNAN,      1'b0, 1'b1, 1'b0});
      v.push_back('{64'h3F800000, 64'hFF800003, 64'hFFC00003, 1'b1, NORMAL, SNAN,      1'b1, 1'b1, 1'b0});
    end else begin
      v.push_back('{64'h3FF0000000000000, 64'h0,                64'h7FF0000000000000, 1'b1, NORMAL, ZERO,      1'b0, 1'b0, 1'b1});
      v.push_back('{64'hBFF0000000000000, 64'h0,                64'hFFF0000000000000, 1'b1, NORMAL, ZERO,      1'b1, 1'b0, 1'b1});
      v.push_back('{64'h0,                64'h8000000000000000, 64'h7FF8000000000000, 1'b1, ZERO,   ZERO,      1'b1, 1'b1, 1'b0});
      v.push_back('{64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 1'b1, INF,    INF,       1'b0, 1'b1, 1'b0});
      v.push_back('{64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000001, 1'b1, SNAN,   NORMAL,    1'b0, 1'b1, 1'b0});
      v.push_back('{64'h3FF0000000000000, 64'h7FF8000000000005, 64'h7FF8000000000005, 1'b1, NORMAL, QNAN,      1'b0, 1'b0, 1'b0});
      v.push_back('{64'h4000000000000000, 64'h0000000000000001, 64'h0,                1'b0, NORMAL, SUBNORMAL, 1'b0, 1'b0, 1'b0});
      v.push_back('{64'h8000000000000000, 64'h3FF0000000000000, 64'h8000000000000000, 1'b1, ZERO,   NORMAL,    1'b1, 1'b0, 1'b0});
      v.push_back('{64'h7FF0000000000000, 64'hBFF0000000000000, 64'hFFF0000000000000, 1'b1, INF,    NORMAL,    1'b1, 1'b0, 1'b0});
      v.push_back('{64'h3FF0000000000000, 64'h7FF0000000000000, 64'h0,                1'b1, NORMAL, INF,       1'b0, 1'b0, 1'b0});
    end
    foreach (v[i]) begin
      apply_pair(v[i].a, v[i].b, lat, res, spec, ac, bc, qs, inv, dz);
      n_checks++;
      if (lat !== 2) begin
        n_fail++; $display("FAIL latency w%0d v%0d: got %0d expected 2", wide, i, lat);
      end
      n_checks++;
      if (spec !== v[i].spec || res !== v[i].res) begin
        n_fail++; $display("FAIL result w%0d v%0d: got special=%b res=%h expected special=%b res=%h",
                           wide, i, spec, res, v[i].spec, v[i].res);
      end
      n_checks++;
      if (ac !== v[i].ac || bc !== v[i].bc) begin
        n_fail++; $display("FAIL class w%0d v%0d: got %0d/%0d expected %0d/%0d",
                           wide, i, ac, bc, v[i].ac, v[i].bc);
      end
      n_checks++;
      if (qs !== v[i].qs) begin
        n_fail++; $display("FAIL q_sign w%0d v%0d: got %b expected %b", wide, i, qs, v[i].qs);
      end
      n_checks++;
      if (inv !== v[i].inv || dz !== v[i].dz) begin
        n_fail++; $display("FAIL flags w%0d v%0d: got inv=%b dz=%b expected inv=%b dz=%b",
                           wide, i, inv, dz, v[i].inv, v[i].dz);
      end
    end
    sel64 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] pa[8], pb[8];
    logic [31:0] held;
    logic        held_v;
    int          sent, rcvd;
    sel64 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        pa[i] = 32'h7FC00000 + 32'(i + 1); pb[i] = 32'h3F800000; exp_q.push_back(pa[i]);
      end else begin
        pa[i] = 32'h3F800000; pb[i] = 32'h7FC00100 + 32'(i); exp_q.push_back(pb[i]);
      end
    end
    sent = 0; rcvd = 0; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        n_checks++;
        if (ov32 !== 1'b1 || res32 !== held) begin
          n_fail++; $display("FAIL stall_hold c%0d: got valid=%b res=%h expected valid=1 res=%h",
                             cyc, ov32, res32, held);
        end
      end
      or32 = (cyc % 2 == 0);
      if (sent < 8) begin
        iv32 = 1'b1; a32 = pa[sent]; b32 = pb[sent];
      end else begin
        iv32 = 1'b0;
      end
      #1;
      if (sent - rcvd == 2) begin
        n_checks++;
        if (ir32 !== or32) begin
          n_fail++; $display("FAIL full_in_ready c%0d: got %b expected %b", cyc, ir32, or32);
        end
      end
      if (ov32 && or32) begin
        n_checks++;
        if (res32 !== exp_q[rcvd]) begin
          n_fail++; $display("FAIL stream_order r%0d: got %h expected %h", rcvd, res32, exp_q[rcvd]);
        end
        rcvd++;
      end
      held_v = ov32 && !or32;
      held   = res32;
      if (iv32 && ir32) sent++;
    end
    @(negedge clk);
    iv32 = 1'b0; or32 = 1'b1;
    n_checks++;
    if (rcvd !== 8 || sent !== 8) begin
      n_fail++; $display("FAIL stream_count: got sent=%0d rcvd=%0d expected 8/8", sent, rcvd);
    end
    @(negedge clk);
    n_checks++;
    if (ov32 !== 1'b0) begin
      n_fail++; $display("FAIL stream_extra: got out_valid=%b expected 0", ov32);
    end
  endtask

  task automatic test_clear_set_same_cycle();
    int waited;
    sel64 = 1'b0; or32 = 1'b1;
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    drive(1'b1, 64'h3F800000, 64'h0);
    @(negedge clk); drive(1'b0, '0, '0);
    waited = 0;
    while (!ov32 && waited < 10) begin @(negedge clk); waited++; end
    clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    n_checks++;
    if (dz32 !== 1'b1) begin
      n_fail++; $display("FAIL clr_vs_set: got st_divzero=%b expected 1", dz32);
    end
    clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    n_checks++;
    if (dz32 !== 1'b0) begin
      n_fail++; $display("FAIL clr_only: got st_divzero=%b expected 0", dz32);
    end
  endtask

  task automatic test_reset_midflight();
    sel64 = 1'b0;
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    or32 = 1'b0;
    drive(1'b1, 64'h3F800000, 64'h0);
    @(negedge clk); drive(1'b1, 64'hBF800000, 64'h0);
    @(negedge clk); drive(1'b0, '0, '0);
    n_checks++;
    if (ov32 !== 1'b1 || ir32 !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got out_valid=%b in_ready=%b expected 1/0", ov32, ir32);
    end
    or32 = 1'b1; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ov32 !== 1'b0 || dz32 !== 1'b0 || inv32 !== 1'b0 || ir32 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got ov=%b dz=%b inv=%b ir=%b expected 0/0/0/0",
                         ov32, dz32, inv32, ir32);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1 || dz32 !== 1'b0) begin
      n_fail++; $display("FAIL after_mid_reset: got ov=%b ir=%b dz=%b expected 0/1/0", ov32, ir32, dz32);
    end
  endtask

  initial begin
    test_reset();
    test_special_table(1'b0);
    test_back_to_back();
    test_clear_set_same_cycle();
    test_reset_midflight();
    test_special_table(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
